// File: rtl/sw_pkg.sv
// Shared defaults and FSM encoding for the SRAM-backed FIFO controller.
package sw_pkg;

   localparam int unsigned WordWDefault = 256;
   localparam int unsigned DepthDefault = 1024;
   localparam int unsigned ByteW        = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoadT = 2'd1,
      StRun   = 2'd2
   } state_e;

endpackage

// File: rtl/sp_sram.sv
// Single-port SRAM, WORD_W x DEPTH, built from byte-wide lanes.
// Active-low chip enable / write enable, one-cycle registered read.
module sp_sram
   import sw_pkg::*;
#(
   parameter int unsigned WORD_W = WordWDefault,
   parameter int unsigned DEPTH  = DepthDefault,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              cen_ni,
   input  logic              wen_ni,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);

   localparam int unsigned NB = WORD_W / ByteW;

   for (genvar b = 0; b < NB; b++) begin : g_lane
      logic [ByteW-1:0] mem_q [DEPTH];
      logic [ByteW-1:0] rdata_q;

      // One byte-wide macro: write or read, never both, when enabled
      always_ff @(posedge clk_i) begin
         if (!cen_ni) begin
            if (!wen_ni) begin
               mem_q[addr_i] <= wdata_i[b*ByteW +: ByteW];
            end else begin
               rdata_q <= mem_q[addr_i];
            end
         end
      end

      assign rdata_o[b*ByteW +: ByteW] = rdata_q;
   end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Circular FIFO in a single-port SRAM. A target byte stream is packed into
// words during LOAD_T; in RUN the PE pops and pushes whole words, with a
// one-entry pending register absorbing a push that collides with a pop.
module sram_fifo_ctrl
   import sw_pkg::*;
#(
   parameter int unsigned WORD_W = WordWDefault,
   parameter int unsigned DEPTH  = DepthDefault,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   localparam int unsigned NB    = WORD_W / ByteW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_init,
   input  logic              i_start_read_t,
   input  logic [7:0]        i_t,
   input  logic              i_t_valid,
   input  logic              i_t_last,
   input  logic              i_PE_request,
   output logic [WORD_W-1:0] o_request_data,
   output logic              o_request_valid,
   input  logic              i_PE_send,
   input  logic [WORD_W-1:0] i_send_data,
   output logic              o_send_ready,
   output logic              o_empty,
   output logic [ADDR_W:0]   o_count,
   output logic              o_overflow,
   output logic              o_busy
);

   localparam int unsigned     KW        = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(DEPTH);
   localparam logic [KW-1:0]   LastLane  = KW'(NB - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [KW-1:0]     k_q, k_d;
   logic [WORD_W-1:0] pack_q, pack_d, pend_data_q, pend_data_d;
   logic              pend_valid_q, pend_valid_d;
   logic              ovf_q, ovf_d;
   logic              rvalid_q, rvalid_d;

   logic              mem_cen_n, mem_wen_n;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata, mem_rdata;
   logic [WORD_W-1:0] packed_word;
   logic              send_ready, rd_acc, send_acc;

   // pend_valid_q low already makes count+pend_valid equal to count here
   assign send_ready = (state_q == StRun) && !pend_valid_q && (count_q < FullCount);
   assign rd_acc     = (state_q == StRun) && i_PE_request && (count_q != '0);
   assign send_acc   = i_PE_send && send_ready;

   // Next-state, SRAM arbitration (read > pending write > new send) and packing
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      k_d          = k_q;
      pack_d       = pack_q;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      ovf_d        = ovf_q;
      rvalid_d     = rd_acc;
      mem_cen_n    = 1'b1;
      mem_wen_n    = 1'b1;
      mem_addr     = wr_ptr_q;
      mem_wdata    = pend_data_q;
      packed_word  = pack_q;
      packed_word[k_q*ByteW +: ByteW] = i_t;

      if (i_PE_send && !send_ready) ovf_d = 1'b1;

      case (state_q)
         StIdle: begin
            if (i_start_read_t) begin
               state_d = StLoadT;
               k_d     = '0;
               pack_d  = '0;
            end
         end
         StLoadT: begin
            if (i_t_valid) begin
               if (count_q == FullCount) begin
                  ovf_d = 1'b1;
                  // A dropped last byte still ends the load
                  if (i_t_last) state_d = StRun;
               end else if (k_q == LastLane || i_t_last) begin
                  mem_cen_n = 1'b0;
                  mem_wen_n = 1'b0;
                  mem_addr  = wr_ptr_q;
                  mem_wdata = packed_word;
                  wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
                  count_d   = count_q + (ADDR_W+1)'(1);
                  k_d       = '0;
                  pack_d    = '0;
                  if (i_t_last) state_d = StRun;
               end else begin
                  pack_d = packed_word;
                  k_d    = k_q + KW'(1);
               end
            end
         end
         StRun: begin
            if (rd_acc) begin
               mem_cen_n = 1'b0;
               mem_addr  = rd_ptr_q;
               rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
               count_d   = count_q - (ADDR_W+1)'(1);
               if (send_acc) begin
                  pend_valid_d = 1'b1;
                  pend_data_d  = i_send_data;
               end
            end else if (pend_valid_q) begin
               mem_cen_n    = 1'b0;
               mem_wen_n    = 1'b0;
               mem_addr     = wr_ptr_q;
               mem_wdata    = pend_data_q;
               pend_valid_d = 1'b0;
               wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
               count_d      = count_q + (ADDR_W+1)'(1);
            end else if (send_acc) begin
               mem_cen_n = 1'b0;
               mem_wen_n = 1'b0;
               mem_addr  = wr_ptr_q;
               mem_wdata = i_send_data;
               wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
               count_d   = count_q + (ADDR_W+1)'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Init wins over everything issued this cycle, including the SRAM access
      if (i_init) begin
         state_d      = StIdle;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         k_d          = '0;
         pack_d       = '0;
         pend_valid_d = 1'b0;
         ovf_d        = 1'b0;
         rvalid_d     = 1'b0;
         mem_cen_n    = 1'b1;
         mem_wen_n    = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         k_q          <= '0;
         pack_q       <= '0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         ovf_q        <= 1'b0;
         rvalid_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         k_q          <= k_d;
         pack_q       <= pack_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         ovf_q        <= ovf_d;
         rvalid_q     <= rvalid_d;
      end
   end

   sp_sram #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_sram (
      .clk_i   (clk),
      .cen_ni  (mem_cen_n),
      .wen_ni  (mem_wen_n),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

   // Gate the SRAM output so data reads zero whenever it is not valid
   assign o_request_data  = rvalid_q ? mem_rdata : '0;
   assign o_request_valid = rvalid_q;
   assign o_send_ready    = send_ready;
   assign o_empty         = (count_q == '0);
   assign o_count         = count_q;
   assign o_overflow      = ovf_q;
   assign o_busy          = (state_q == StLoadT);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with 4 byte lanes and 4 words of storage.
module tb_sram_fifo_ctrl;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst, init, start, t_valid, t_last, req, send;
   logic [7:0]        t;
   logic [WORD_W-1:0] sdata, rdata;
   logic              rvalid, sready, empty, ovf, busy;
   logic [ADDR_W:0]   count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   sram_fifo_ctrl #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_init          (init),
      .i_start_read_t  (start),
      .i_t             (t),
      .i_t_valid       (t_valid),
      .i_t_last        (t_last),
      .i_PE_request    (req),
      .o_request_data  (rdata),
      .o_request_valid (rvalid),
      .i_PE_send       (send),
      .i_send_data     (sdata),
      .o_send_ready    (sready),
      .o_empty         (empty),
      .o_count         (count),
      .o_overflow      (ovf),
      .o_busy          (busy)
   );

   // Advance one edge and settle; outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; init = 1'b0; start = 1'b0; t = '0; t_valid = 1'b0; t_last = 1'b0;
      req = 1'b0; send = 1'b0; sdata = '0;
      tick();
      tick();
      rst = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else pass_cnt++;
      total_cnt++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid); else pass_cnt++;
      total_cnt++; if (sready !== 1'b0) $display("FAIL reset_sready: got %b want 0", sready); else pass_cnt++;
      total_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else pass_cnt++;
   endtask

   // Bytes 01..06, last on 06: two words, RUN right after the second write
   task automatic test_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      total_cnt++; if (busy !== 1'b1) $display("FAIL load_busy_on: got %b want 1", busy); else pass_cnt++;
      for (int i = 1; i <= 6; i++) begin
         t = 8'(i); t_valid = 1'b1; t_last = (i == 6);
         tick();
         if (i == 4) begin
            total_cnt++; if (count !== 3'd1) $display("FAIL load_count_w0: got %0d want 1", count); else pass_cnt++;
         end
         if (i == 5) begin
            total_cnt++; if (busy !== 1'b1) $display("FAIL load_busy_mid: got %b want 1", busy); else pass_cnt++;
         end
      end
      t_valid = 1'b0; t_last = 1'b0;
      total_cnt++; if (count !== 3'd2) $display("FAIL load_count: got %0d want 2", count); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL load_busy_off: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (sready !== 1'b1) $display("FAIL load_run_sready: got %b want 1", sready); else pass_cnt++;
   endtask

   // Back-to-back pops, then a pop on an empty FIFO is ignored
   task automatic test_back_to_back();
      req = 1'b1;
      tick();
      total_cnt++; if (rvalid !== 1'b1) $display("FAIL pop0_valid: got %b want 1", rvalid); else pass_cnt++;
      total_cnt++; if (rdata !== 32'h04030201) $display("FAIL pop0_data: got %h want 04030201", rdata); else pass_cnt++;
      tick();
      total_cnt++; if (rvalid !== 1'b1) $display("FAIL pop1_valid: got %b want 1", rvalid); else pass_cnt++;
      total_cnt++; if (rdata !== 32'h00000605) $display("FAIL pop1_data: got %h want 00000605", rdata); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL pop1_empty: got %b want 1", empty); else pass_cnt++;
      tick();
      req = 1'b0;
      total_cnt++; if (rvalid !== 1'b0) $display("FAIL pop_empty_valid: got %b want 0", rvalid); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL pop_empty_ovf: got %b want 0", ovf); else pass_cnt++;
   endtask

   // Push collides with pop at count 3: pop wins, push is pended one cycle
   task automatic test_collision();
      logic [31:0] exp_pop [3];
      exp_pop[0] = 32'h22; exp_pop[1] = 32'h33; exp_pop[2] = 32'hAA;
      send = 1'b1;
      sdata = 32'h11; tick();
      sdata = 32'h22; tick();
      sdata = 32'h33; tick();
      total_cnt++; if (count !== 3'd3) $display("FAIL coll_pre_count: got %0d want 3", count); else pass_cnt++;
      sdata = 32'hAA; req = 1'b1;
      tick();
      send = 1'b0; req = 1'b0;
      total_cnt++; if (rdata !== 32'h11 || rvalid !== 1'b1) $display("FAIL coll_read: got %h/%b want 11/1", rdata, rvalid); else pass_cnt++;
      total_cnt++; if (sready !== 1'b0) $display("FAIL coll_sready_low: got %b want 0", sready); else pass_cnt++;
      total_cnt++; if (count !== 3'd2) $display("FAIL coll_count_mid: got %0d want 2", count); else pass_cnt++;
      tick();
      total_cnt++; if (sready !== 1'b1) $display("FAIL coll_sready_back: got %b want 1", sready); else pass_cnt++;
      total_cnt++; if (count !== 3'd3) $display("FAIL coll_count_back: got %0d want 3", count); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL coll_ovf: got %b want 0", ovf); else pass_cnt++;
      req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++; if (rdata !== exp_pop[i]) $display("FAIL coll_pop%0d: got %h want %h", i, rdata, exp_pop[i]); else pass_cnt++;
      end
      req = 1'b0;
      tick();
   endtask

   // Fill to DEPTH across the pointer wrap, overflow on a 5th push, drain in order
   task automatic test_full_wrap();
      send = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sdata = 32'hA0 + 32'(i);
         tick();
      end
      total_cnt++; if (sready !== 1'b0) $display("FAIL full_sready: got %b want 0", sready); else pass_cnt++;
      total_cnt++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL full_ovf_pre: got %b want 0", ovf); else pass_cnt++;
      sdata = 32'hEE;
      tick();
      send = 1'b0;
      total_cnt++; if (ovf !== 1'b1) $display("FAIL full_ovf: got %b want 1", ovf); else pass_cnt++;
      total_cnt++; if (count !== 3'd4) $display("FAIL full_count_drop: got %0d want 4", count); else pass_cnt++;
      req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total_cnt++;
         if (rvalid !== 1'b1 || rdata !== 32'hA0 + 32'(i))
            $display("FAIL wrap_pop%0d: got %h/%b want %h/1", i, rdata, rvalid, 32'hA0 + 32'(i));
         else pass_cnt++;
      end
      req = 1'b0;
      tick();
      total_cnt++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else pass_cnt++;
   endtask

   // Init in the middle of a pop stream clears everything and returns to IDLE
   task automatic test_init();
      send = 1'b1;
      sdata = 32'h55; tick();
      sdata = 32'h66; tick();
      send = 1'b0; req = 1'b1;
      tick();
      total_cnt++; if (rdata !== 32'h55) $display("FAIL init_pre_pop: got %h want 55", rdata); else pass_cnt++;
      init = 1'b1;
      tick();
      init = 1'b0;
      total_cnt++; if (rvalid !== 1'b0) $display("FAIL init_rvalid: got %b want 0", rvalid); else pass_cnt++;
      total_cnt++; if (count !== 3'd0) $display("FAIL init_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL init_ovf: got %b want 0", ovf); else pass_cnt++;
      total_cnt++; if (sready !== 1'b0 || busy !== 1'b0) $display("FAIL init_idle: got sready %b busy %b want 0 0", sready, busy); else pass_cnt++;
      tick();
      req = 1'b0;
      total_cnt++; if (rvalid !== 1'b0) $display("FAIL init_req_ignored: got %b want 0", rvalid); else pass_cnt++;
   endtask

   // Reset in the middle of a target load
   task automatic test_rst_mid_load();
      send = 1'b1;
      tick();
      send = 1'b0;
      total_cnt++; if (ovf !== 1'b1) $display("FAIL idle_send_ovf: got %b want 1", ovf); else pass_cnt++;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         t = 8'hC0 + 8'(i); t_valid = 1'b1;
         tick();
      end
      t_valid = 1'b0;
      total_cnt++; if (count !== 3'd1 || busy !== 1'b1) $display("FAIL midload_state: got count %0d busy %b want 1 1", count, busy); else pass_cnt++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf); else pass_cnt++;
      total_cnt++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_collision();
      test_full_wrap();
      test_init();
      test_rst_mid_load();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter WORD_W, default 256: SRAM word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024: words of storage; SHALL be a power of two.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): address and pointer width.
REQ-004 Parameter NB, default WORD_W/8: byte lanes per word; derived, not overridden.
REQ-005 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_init  in  1  clear FIFO, return to IDLE.
- i_start_read_t  in  1  begin target-sequence load.
- i_t  in  8  target byte.
- i_t_valid  in  1  i_t valid this cycle.
- i_t_last  in  1  marks last target byte; qualified by i_t_valid.
- i_PE_request  in  1  PE pops one word.
- o_request_data  out  WORD_W  popped word.
- o_request_valid  out  1  o_request_data valid.
- i_PE_send  in  1  PE pushes one word.
- i_send_data  in  WORD_W  pushed word.
- o_send_ready  out  1  push accepted when high with i_PE_send.
- o_empty  out  1  SRAM word count is zero.
- o_count  out  ADDR_W+1  words stored in SRAM.
- o_overflow  out  1  sticky; a byte or word was dropped.
- o_busy  out  1  target load in progress.

Function
REQ-006 The block SHALL implement a circular FIFO in one single-port SRAM: at most one access (read or write) per cycle.
REQ-007 FSM states SHALL be IDLE, LOAD_T, RUN; IDLE->LOAD_T on i_start_read_t; LOAD_T->RUN the cycle after the word holding i_t_last is written; any state->IDLE on i_init.
REQ-008 In LOAD_T, each valid byte SHALL be placed in lane k (lane 0 = bits 7:0), with k incrementing per byte.
REQ-009 When k = NB-1 or i_t_last, the packed word SHALL be written at wr_ptr with unfilled lanes zero, followed by wr_ptr+1, count+1, and k=0.
REQ-010 In LOAD_T with count = DEPTH, bytes SHALL be dropped and o_overflow set.
REQ-011 o_busy SHALL be 1 exactly while the FSM is in LOAD_T.
REQ-012 In RUN, i_PE_request with count>0 SHALL read at rd_ptr, then perform rd_ptr+1 and count-1.
REQ-013 For a request accepted at cycle N, o_request_valid SHALL be high and o_request_data SHALL hold the word at cycle N+1. Back-to-back requests SHALL sustain one word per cycle.
REQ-014 i_PE_request with count=0, or outside RUN, SHALL be ignored: no read, o_request_valid 0, no flag.
REQ-015 o_send_ready SHALL equal (state==RUN) && !pend_valid && (count+pend_valid < DEPTH).
REQ-016 A send presented while o_send_ready is low SHALL be dropped and SHALL set o_overflow.
REQ-017 Access priority per cycle SHALL be: accepted read > pending write > new accepted send.
REQ-018 An accepted send that loses arbitration SHALL be captured in a one-entry pending register (pend_valid, pend_data) and written on the next cycle with no read.
REQ-019 Simultaneous request and send with count=0: the request SHALL be ignored and the send written directly.
REQ-020 Pointers SHALL wrap modulo DEPTH. count SHALL change only on actual SRAM writes and reads, and SHALL stay unchanged when one of each occurs in the same cycle (impossible on a single port).
REQ-021 o_empty SHALL equal (count==0).
REQ-022 i_init SHALL, on the next edge: clear the pointers, count, k, pend_valid and o_overflow; force o_request_valid 0; discard any in-flight read; and enter IDLE. i_init SHALL override all same-cycle inputs.

Reset
REQ-023 On rst, sampled at a clk edge: state IDLE; pointers, count, k and pend_valid 0; all outputs 0 except o_empty=1.
REQ-024 SRAM contents SHALL NOT be cleared by reset or i_init.

Structure
REQ-025 The shared package sw_pkg SHALL hold default WORD_W (256), DEPTH (1024), the byte width (8) and the FSM state encoding.
REQ-026 Storage SHALL be one sub-module, sp_sram (parametrised WORD_W x DEPTH, single port, 1-cycle read latency, CEN/WEN active-low). It maps to NB byte-wide macros.

Verification
REQ-027 NB=4: load bytes 01..06 with last on 06 -> 2 words 0x04030201, 0x00000605; count=2; RUN after 1 cycle; o_busy low.
REQ-028 Request at cycles N and N+1 -> o_request_valid at N+1 and N+2 carrying words 0 and 1; o_empty=1 at N+2.
REQ-029 count=3, send 0xAA and request in the same cycle -> read first, 0xAA pended and written next cycle, o_send_ready low for 1 cycle, count returns to 3.
REQ-030 DEPTH=4: push 4 words -> o_send_ready 0; a 5th send sets o_overflow; pop 4 words returns them in order across the pointer wrap.
REQ-031 i_init during an active request stream -> o_request_valid 0 next cycle, count 0, IDLE; a following i_request is ignored.
REQ-032 rst asserted mid-LOAD_T -> next cycle IDLE, o_busy 0, o_empty 1, o_overflow 0.
